ofs_plat_prim_burstcount1_write_gen: RTL and testbench

Transmit-side companion to the burst SOP/EOP tracker. It merges a burst command stream (address plus a burst count with origin 1) with a write-data beat stream into an Avalon-MM write channel. It drives address and burstcount stable across every beat of a packet and flags SOP/EOP on each beat. It sits in front of any Avalon write master port whose downstream logic tracks packets by burst count.

---
 rtl/ofs_plat_prim_burstcount1_write_gen.sv | 142 ++++++++++++++
 tb/tb_ofs_plat_prim_burstcount1_write_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_plat_prim_burstcount1_write_gen.sv
// Burst write generator: merges a burst command stream (address plus
// origin-1 burst count) with a write-data beat stream into an Avalon-MM
// write channel. Address and burstcount are held for the whole burst and
// every beat carries SOP/EOP flags.
//
// Handshake rule for every stream here: a transfer happens on a rising
// clock edge where valid && ready are both high. Valid never depends on
// ready. Ready may depend combinationally on valid.
module ofs_plat_prim_burstcount1_write_gen #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7
) (
  input  logic                        clk,
  input  logic                        reset_n,

  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [ADDR_WIDTH-1:0]       cmd_address,
  input  logic [BURST_CNT_WIDTH-1:0]  cmd_burstcount,

  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic [DATA_WIDTH/8-1:0]     wr_byteenable,

  output logic                        avm_write,
  input  logic                        avm_waitrequest,
  output logic [ADDR_WIDTH-1:0]       avm_address,
  output logic [BURST_CNT_WIDTH-1:0]  avm_burstcount,
  output logic [DATA_WIDTH-1:0]       avm_writedata,
  output logic [DATA_WIDTH/8-1:0]     avm_byteenable,
  output logic                        avm_sop,
  output logic                        avm_eop,

  output logic                        err_burst0,

  // Debug visibility of the internal burst tracker.
  output logic                        dbg_state,
  output logic [BURST_CNT_WIDTH-1:0]  dbg_beats_rem
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                       state;
  logic [BURST_CNT_WIDTH-1:0]   beats_rem;

  logic load_en;
  logic bc_zero;
  logic first_load;
  logic next_load;
  logic drop_cmd;

  // The output register can take a new beat when it is empty or its beat
  // is retiring this cycle.
  assign load_en = !avm_write || !avm_waitrequest;
  assign bc_zero = (cmd_burstcount == '0);

  // Ready generation. A zero-length command is discarded without a data
  // beat; it is still gated by load_en so nothing is accepted while the
  // Avalon side is stalled.
  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (bc_zero) begin
            cmd_ready = load_en;
          end else begin
            cmd_ready = wr_valid && load_en;
            wr_ready  = load_en;
          end
        end
      end
      BUSY: begin
        wr_ready = load_en;
      end
      default: begin
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
      end
    endcase
  end

  assign first_load = (state == IDLE) && cmd_valid && !bc_zero &&
                      cmd_ready && wr_valid;
  assign next_load  = (state == BUSY) && wr_valid && wr_ready;
  assign drop_cmd   = (state == IDLE) && cmd_valid && bc_zero && cmd_ready;

  // Burst FSM and output beat register. Data fields are only meaningful
  // while avm_write is set, so they are not reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      beats_rem  <= '0;
      avm_write  <= 1'b0;
      avm_sop    <= 1'b0;
      avm_eop    <= 1'b0;
      err_burst0 <= 1'b0;
    end else begin
      if (drop_cmd) begin
        err_burst0 <= 1'b1;
      end

      if (load_en) begin
        if (first_load) begin
          avm_write      <= 1'b1;
          avm_sop        <= 1'b1;
          avm_eop        <= (cmd_burstcount == BURST_CNT_WIDTH'(1));
          avm_address    <= cmd_address;
          avm_burstcount <= cmd_burstcount;
          avm_writedata  <= wr_data;
          avm_byteenable <= wr_byteenable;
          beats_rem      <= cmd_burstcount - 1'b1;
          state          <= (cmd_burstcount == BURST_CNT_WIDTH'(1)) ? IDLE : BUSY;
        end else if (next_load) begin
          avm_write      <= 1'b1;
          avm_sop        <= 1'b0;
          avm_eop        <= (beats_rem == BURST_CNT_WIDTH'(1));
          avm_writedata  <= wr_data;
          avm_byteenable <= wr_byteenable;
          beats_rem      <= beats_rem - 1'b1;
          if (beats_rem == BURST_CNT_WIDTH'(1)) begin
            state <= IDLE;
          end
        end else begin
          avm_write <= 1'b0;
          avm_sop   <= 1'b0;
          avm_eop   <= 1'b0;
        end
      end
    end
  end

  assign dbg_state     = state;
  assign dbg_beats_rem = beats_rem;

endmodule

// File: tb/tb_ofs_plat_prim_burstcount1_write_gen.sv
// Bench for the burst write generator: directed single-beat, back-to-back
// and reset-mid-burst cases plus randomized command/data/backpressure
// traffic checked against an expected beat queue.
module tb_ofs_plat_prim_burstcount1_write_gen;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int BCW = 7;
  localparam int EW  = AW + BCW + DW + BW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_address = '0;
  logic [BCW-1:0]  cmd_burstcount = '0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [DW-1:0]   wr_data = '0;
  logic [BW-1:0]   wr_byteenable = '0;
  logic            avm_write;
  logic            avm_waitrequest = 1'b0;
  logic [AW-1:0]   avm_address;
  logic [BCW-1:0]  avm_burstcount;
  logic [DW-1:0]   avm_writedata;
  logic [BW-1:0]   avm_byteenable;
  logic            avm_sop;
  logic            avm_eop;
  logic            err_burst0;
  logic            dbg_state;
  logic [BCW-1:0]  dbg_beats_rem;

  ofs_plat_prim_burstcount1_write_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_address(cmd_address), .cmd_burstcount(cmd_burstcount),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_byteenable(wr_byteenable),
    .avm_write(avm_write), .avm_waitrequest(avm_waitrequest),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_sop(avm_sop), .avm_eop(avm_eop),
    .err_burst0(err_burst0),
    .dbg_state(dbg_state), .dbg_beats_rem(dbg_beats_rem)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int eop_seen = 0;
  int nz_cmds  = 0;
  logic mon_en     = 1'b0;
  logic rec_cyc    = 1'b0;
  logic wr_rand_en = 1'b0;

  logic [EW-1:0]  exp_q[$];
  logic [AW-1:0]  cmd_addr_q[$];
  logic [BCW-1:0] cmd_bc_q[$];
  logic [DW-1:0]  data_q[$];
  logic [BW-1:0]  be_q[$];
  int             ret_cyc_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] cur_beat();
    return {avm_address, avm_burstcount, avm_writedata, avm_byteenable,
            avm_sop, avm_eop};
  endfunction

  // Reference model: a nonzero command of N beats expands into N beats that
  // all carry the command address and count, consuming the next N data
  // beats in order, SOP on the first and EOP on the last.
  task automatic add_cmd(input logic [AW-1:0] a, input logic [BCW-1:0] bc);
    logic [DW-1:0] d;
    logic [BW-1:0] be;
    cmd_addr_q.push_back(a);
    cmd_bc_q.push_back(bc);
    if (bc != 0) begin
      nz_cmds++;
      for (int b = 0; b < int'(bc); b++) begin
        d  = DW'($urandom);
        be = BW'($urandom);
        data_q.push_back(d);
        be_q.push_back(be);
        exp_q.push_back({a, bc, d, be, (b == 0), (b == int'(bc) - 1)});
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drivers start and end at posedge+1; handshakes are sampled at negedge.
  task automatic drive_cmds(input int gap_max);
    logic hs;
    while (cmd_bc_q.size() != 0) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      cmd_valid      = 1'b1;
      cmd_address    = cmd_addr_q.pop_front();
      cmd_burstcount = cmd_bc_q.pop_front();
      do begin
        @(negedge clk); hs = cmd_ready;
        @(posedge clk); #1;
      end while (!hs);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic drive_data(input int gap_max);
    logic hs;
    while (data_q.size() != 0) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      wr_valid      = 1'b1;
      wr_data       = data_q.pop_front();
      wr_byteenable = be_q.pop_front();
      do begin
        @(negedge clk); hs = wr_ready;
        @(posedge clk); #1;
      end while (!hs);
      wr_valid = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      @(posedge clk); guard++;
    end
    #1;
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Backpressure generator.
  initial begin
    forever begin
      @(posedge clk); #1;
      avm_waitrequest = wr_rand_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: retired beats against the expected queue, stall stability.
  initial begin
    logic          prev_stall = 1'b0;
    logic [EW-1:0] snap = '0;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("stall_hold", 64'(cur_beat()), 64'(snap));
          check_eq("stall_write", 64'(avm_write), 64'd1);
        end
        prev_stall = 1'b0;
        if (avm_write && avm_waitrequest) begin
          check_eq("stall_rdy", 64'({cmd_ready, wr_ready}), 64'd0);
          snap = cur_beat();
          prev_stall = 1'b1;
        end else if (avm_write) begin
          if (rec_cyc) ret_cyc_q.push_back(cyc);
          if (avm_eop) eop_seen++;
          if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", 64'(cur_beat()), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_eq("beat", 64'(cur_beat()), 64'(e));
          end
        end
      end
    end
  end

  // Watchdog.
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] d;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_write", 64'(avm_write), 64'd0);
    check_eq("rst_sop_eop", 64'({avm_sop, avm_eop}), 64'd0);
    check_eq("rst_err", 64'(err_burst0), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'd0);
    check_eq("rst_rem", 64'(dbg_beats_rem), 64'd0);
    check_eq("rst_wr_ready", 64'(wr_ready), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Data without a command is held off.
    wr_valid = 1'b1;
    @(negedge clk);
    check_eq("hold_off", 64'(wr_ready), 64'd0);

    // Single-beat burst, one-cycle latency.
    d = 32'hCAFE_0001;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_address = 16'h0100; cmd_burstcount = 7'd1;
    wr_data = d; wr_byteenable = 4'hF;
    @(negedge clk);
    check_eq("single_rdy", 64'({cmd_ready, wr_ready}), 64'd3);
    @(posedge clk); #1;
    cmd_valid = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check_eq("single_beat", 64'({avm_write, cur_beat()}),
             64'({1'b1, 16'h0100, 7'd1, d, 4'hF, 1'b1, 1'b1}));
    check_eq("single_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("single_after", 64'(avm_write), 64'd0);
    @(posedge clk); #1;

    // Back-to-back bc 3 and bc 2, no backpressure, no gaps.
    mon_en = 1'b1; rec_cyc = 1'b1;
    add_cmd(16'h0400, 7'd3);
    add_cmd(16'h0500, 7'd2);
    fork
      drive_cmds(0);
      drive_data(0);
    join
    drain("b2b_drain");
    repeat (2) @(posedge clk); #1;
    rec_cyc = 1'b0;
    check_eq("b2b_count", 64'(ret_cyc_q.size()), 64'd5);
    if (ret_cyc_q.size() == 5)
      check_eq("b2b_span", 64'(ret_cyc_q[4] - ret_cyc_q[0]), 64'd4);

    // Directed list (stalled 4-beat, max burst, zero count) plus random.
    wr_rand_en = 1'b1;
    add_cmd(16'h0200, 7'd4);
    add_cmd(16'h0600, 7'd127);
    add_cmd(16'h0700, 7'd0);
    add_cmd(16'h0800, 7'd2);
    for (int i = 0; i < 40; i++)
      add_cmd(AW'($urandom), BCW'($urandom_range(0, 9)));
    fork
      drive_cmds(3);
      drive_data(2);
    join
    drain("rand_drain");
    wr_rand_en = 1'b0;
    repeat (3) @(posedge clk); #1;
    mon_en = 1'b0;
    @(negedge clk);
    check_eq("eop_count", 64'(eop_seen), 64'(nz_cmds));
    check_eq("err_sticky", 64'(err_burst0), 64'd1);
    check_eq("idle_state", 64'(dbg_state), 64'd0);
    check_eq("idle_rem", 64'(dbg_beats_rem), 64'd0);
    @(posedge clk); #1;

    // Reset after beat 2 of a bc 4 burst.
    cmd_valid = 1'b1; cmd_address = 16'h0300; cmd_burstcount = 7'd4;
    wr_valid = 1'b1; wr_data = 32'h1111_0001;
    @(posedge clk); #1;
    cmd_valid = 1'b0; wr_data = 32'h1111_0002;
    @(posedge clk); #1;
    wr_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    check_eq("mid_beat2", 64'({avm_write, avm_sop, avm_eop}), 64'b100);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_write", 64'(avm_write), 64'd0);
    check_eq("mid_rst_err", 64'(err_burst0), 64'd0);
    check_eq("mid_rst_state", 64'({dbg_state, dbg_beats_rem}), 64'd0);
    @(posedge clk); #1;
    d = 32'hBEEF_0042;
    cmd_valid = 1'b1; cmd_address = 16'h0900; cmd_burstcount = 7'd1;
    wr_valid = 1'b1; wr_data = d; wr_byteenable = 4'h5;
    @(posedge clk); #1;
    cmd_valid = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check_eq("post_rst_beat", 64'({avm_write, cur_beat()}),
             64'({1'b1, 16'h0900, 7'd1, d, 4'h5, 1'b1, 1'b1}));
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
